relu_backward: RTL and testbench

Streaming ReLU gradient unit for the training path of the CNN accelerator. During the forward pass it records one mask bit per activation: 1 when the pre-activation sign bit is clear, 0 when set, matching the forward ReLU pass/zero decision. During the backward pass it consumes upstream gradients in the same order and either passes or zeroes each one. The block sits between the loss/next-layer gradient stream and the convolution weight-update logic. Valid/ready handshakes throughout.

---
 rtl/cnn_pkg.sv | 13 +
 rtl/mask_fifo.sv | 70 +++++++
 rtl/relu_backward.sv | 80 ++++++++
 tb/tb_relu_backward.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared defaults for the CNN training-path blocks
package cnn_pkg;

  // Activation/gradient word width (signed fixed point).
  localparam int N_DEFAULT = 16;

  // Fractional bits of the fixed-point format; documentary only.
  localparam int Q_DEFAULT = 12;

  // Forward-mask buffer entries; must be a power of two, at least 2.
  localparam int DEPTH_DEFAULT = 64;

endpackage : cnn_pkg

// File: rtl/mask_fifo.sv
// rtl/mask_fifo.sv - 1-bit DEPTH-deep ReLU mask FIFO, no bypass
module mask_fifo
  import cnn_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        push,
  input  logic        push_bit,
  input  logic        pop,
  output logic        pop_bit,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty
);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Guard against overflow/underflow even if the caller misbehaves; full and
  // empty come from the registered count, so neither side bypasses the other.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign pop_bit = mem[rd_ptr];

  // Mask storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_bit;
    end
  end

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule : mask_fifo

// File: rtl/relu_backward.sv
// rtl/relu_backward.sv - streaming ReLU gradient masking unit
module relu_backward
  import cnn_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int Q     = Q_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     fwd_valid,
  output logic                     fwd_ready,
  input  logic [N-1:0]             fwd_act,
  input  logic                     grad_valid,
  output logic                     grad_ready,
  input  logic [N-1:0]             grad_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             grad_out,
  output logic [$clog2(DEPTH):0]   mask_count
);

  // Q describes the fixed-point format of the data but the mask logic is
  // sign-only, so it only participates in this range sanity hook.
  if (Q >= N) begin : g_q_not_below_n
  end

  logic push;
  logic pop;
  logic mask_in;
  logic mask_out;
  logic fifo_full;
  logic fifo_empty;

  // A non-negative pre-activation (sign clear, zero included) passed the
  // forward ReLU, so its gradient passes too.
  assign mask_in = ~fwd_act[N-1];

  // Readiness is held low while reset is asserted so nothing can be taken
  // before the pipeline is out of reset; output stage may only load when it
  // is empty or draining this cycle.
  assign fwd_ready  = !reset && !clear && !fifo_full;
  assign grad_ready = !reset && !clear && !fifo_empty && (!out_valid || out_ready);

  assign push = fwd_valid && fwd_ready;
  assign pop  = grad_valid && grad_ready;

  mask_fifo #(
    .DEPTH (DEPTH)
  ) u_mask_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .push     (push),
    .push_bit (mask_in),
    .pop      (pop),
    .pop_bit  (mask_out),
    .count    (mask_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Output register: load masked gradient on pop, drop valid once drained.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      grad_out  <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
      grad_out  <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      grad_out  <= mask_out ? grad_in : '0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule : relu_backward

// File: tb/tb_relu_backward.sv
// tb/tb_relu_backward.sv - self-checking bench for relu_backward
module tb_relu_backward;
  import cnn_pkg::*;

  localparam int N     = N_DEFAULT;
  localparam int DEPTH = DEPTH_DEFAULT;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          fwd_valid;
  logic          fwd_ready;
  logic [N-1:0]  fwd_act;
  logic          grad_valid;
  logic          grad_ready;
  logic [N-1:0]  grad_in;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  grad_out;
  logic [CW-1:0] mask_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of pass/zero decisions plus the output stage.
  bit            mq[$];
  bit            m_ov;
  logic [N-1:0]  m_go;

  always #5 clk = ~clk;

  relu_backward #(.N(N), .Q(Q_DEFAULT), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .fwd_valid  (fwd_valid),
    .fwd_ready  (fwd_ready),
    .fwd_act    (fwd_act),
    .grad_valid (grad_valid),
    .grad_ready (grad_ready),
    .grad_in    (grad_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .grad_out   (grad_out),
    .mask_count (mask_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs just after an edge, check readiness against
  // the model, advance the model across the edge, then check registered state.
  task automatic cycle(input bit clr, input bit fv, input logic [N-1:0] act,
                       input bit gv, input logic [N-1:0] g, input bit ordy,
                       input string tag);
    bit e_fr, e_gr, do_push, do_pop, m;
    clear = clr; fwd_valid = fv; fwd_act = act;
    grad_valid = gv; grad_in = g; out_ready = ordy;
    #1;
    e_fr = !clr && (mq.size() < DEPTH);
    e_gr = !clr && (mq.size() != 0) && (!m_ov || ordy);
    check({tag, ".fwd_ready"}, 32'(fwd_ready), 32'(e_fr));
    check({tag, ".grad_ready"}, 32'(grad_ready), 32'(e_gr));
    do_push = fv && e_fr;
    do_pop  = gv && e_gr;
    @(posedge clk);
    if (clr) begin
      mq.delete();
      m_ov = 1'b0;
      m_go = '0;
    end else begin
      if (do_pop) begin
        m    = mq.pop_front();
        m_ov = 1'b1;
        m_go = m ? g : '0;
      end else if (ordy) begin
        m_ov = 1'b0;
      end
      if (do_push) mq.push_back(($signed(act) >= 0));
    end
    #1;
    check({tag, ".mask_count"}, 32'(mask_count), 32'(mq.size()));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    if (m_ov) check({tag, ".grad_out"}, 32'(grad_out), 32'(m_go));
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH + 4 && (mq.size() != 0 || m_ov); i++)
      cycle(0, 0, '0, 1, 16'h0123, 1, "drain");
  endtask

  initial begin
    logic [N-1:0] acts[4];
    logic [N-1:0] exp_basic[4];
    reset = 1'b1; clear = 1'b0; fwd_valid = 1'b0; fwd_act = '0;
    grad_valid = 1'b0; grad_in = '0; out_ready = 1'b0;
    m_ov = 1'b0; m_go = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.fwd_ready", 32'(fwd_ready), 32'd0);
    check("rst.grad_ready", 32'(grad_ready), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.grad_out", 32'(grad_out), 32'd0);
    check("rst.mask_count", 32'(mask_count), 32'd0);
    reset = 1'b0;
    #1;
    check("rst.fwd_ready_after", 32'(fwd_ready), 32'd1);

    // Basic masking
    acts[0] = 16'h1000; acts[1] = 16'hF800; acts[2] = 16'h0000; acts[3] = 16'h8000;
    exp_basic[0] = 16'h0400; exp_basic[1] = 16'h0000;
    exp_basic[2] = 16'h0400; exp_basic[3] = 16'h0000;
    for (int i = 0; i < 4; i++) cycle(0, 1, acts[i], 0, '0, 1, "basic.push");
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, '0, 1, 16'h0400, 1, "basic.pop");
      check("basic.grad_out_const", 32'(grad_out), 32'(exp_basic[i]));
    end
    cycle(0, 0, '0, 0, '0, 1, "basic.idle");

    // Empty / stall
    cycle(0, 0, '0, 1, 16'h1111, 1, "empty.nopop");
    cycle(0, 1, 16'h0005, 1, 16'h2222, 0, "empty.push_t");
    cycle(0, 1, 16'h0006, 1, 16'h3333, 0, "empty.pop_t1");
    cycle(0, 0, '0, 1, 16'h4444, 0, "stall.hold");
    check("stall.grad_out_hold", 32'(grad_out), 32'h3333);
    cycle(0, 0, '0, 1, 16'h5555, 1, "stall.release");
    drain();

    // Full
    for (int i = 0; i < DEPTH; i++)
      cycle(0, 1, 16'($urandom), 0, '0, 1, "full.fill");
    check("full.count64", 32'(mask_count), 32'(DEPTH));
    cycle(0, 1, 16'h0001, 1, 16'h0777, 1, "full.pop_push");
    check("full.count63", 32'(mask_count), 32'(DEPTH - 1));
    cycle(0, 0, '0, 0, '0, 1, "full.ready_again");
    drain();

    // Randomized wrap-around
    for (int i = 0; i < 200; i++)
      cycle(0, 1'($urandom_range(0, 1)), 16'($urandom),
            ($urandom_range(0, 3) != 0), 16'($urandom),
            ($urandom_range(0, 3) != 0), "rand");
    drain();

    // Clear with 10 masks stored and a pending output
    for (int i = 0; i < 11; i++) cycle(0, 1, 16'($urandom), 0, '0, 1, "clr.fill");
    cycle(0, 0, '0, 1, 16'h0abc, 0, "clr.load");
    check("clr.count10", 32'(mask_count), 32'd10);
    cycle(1, 1, 16'h0001, 1, 16'h0def, 1, "clr.flush");
    check("clr.count0", 32'(mask_count), 32'd0);
    check("clr.out_valid0", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stream
    cycle(0, 1, 16'h8001, 0, '0, 1, "arst.pre1");
    cycle(0, 1, 16'h0002, 0, '0, 1, "arst.pre2");
    cycle(0, 0, '0, 1, 16'h0123, 0, "arst.pre3");
    #2;
    reset = 1'b1;
    #1;
    check("arst.out_valid", 32'(out_valid), 32'd0);
    check("arst.grad_out", 32'(grad_out), 32'd0);
    check("arst.mask_count", 32'(mask_count), 32'd0);
    check("arst.fwd_ready", 32'(fwd_ready), 32'd0);
    check("arst.grad_ready", 32'(grad_ready), 32'd0);
    mq.delete(); m_ov = 1'b0; m_go = '0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    cycle(0, 1, 16'h7000, 0, '0, 1, "arst.push_pos");
    cycle(0, 1, 16'hC000, 1, 16'h0246, 1, "arst.pop_first");
    check("arst.first_mask", 32'(grad_out), 32'h0246);
    cycle(0, 0, '0, 1, 16'h0135, 1, "arst.pop_second");
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_relu_backward
